iir_biquad_cascade: RTL

IIR_BIQUAD_CASCADE -- requirements
Module: iir_biquad_cascade

---
 rtl/iir_biquad_cascade_if.sv | 28 ++
 rtl/iir_biquad_cascade.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/iir_biquad_cascade_if.sv
// Streaming interface for iir_biquad_cascade.
//   in_valid/in_ready/in_data/in_ch    : sample input handshake
//   out_valid/out_data/out_ch          : one-cycle result pulse, data/channel held until next result
// master = sample producer / result consumer, slave = filter block.
interface iir_biquad_cascade_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NUM_CH = 2
);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic [CH_W-1:0]          in_ch;
   logic                     out_valid;
   logic signed [DATA_W-1:0] out_data;
   logic [CH_W-1:0]          out_ch;

   modport master (
      output in_valid, in_data, in_ch,
      input  in_ready, out_valid, out_data, out_ch
   );

   modport slave (
      input  in_valid, in_data, in_ch,
      output in_ready, out_valid, out_data, out_ch
   );
endinterface

// File: rtl/iir_biquad_cascade.sv
// Multi-channel cascade of direct-form-I biquad sections sharing a single multiplier.
// One product is accumulated per cycle: each section takes 5 MAC cycles plus one write-back.
// Ports:
//   clk, reset  : clock, synchronous active-low reset
//   io (slave)  : sample in / result out stream (see iir_biquad_cascade_if)
//   coef_we/coef_addr/coef_data : coefficient write, addr = section*5 + tap (b0,b1,b2,a1,a2)
//   hist_clr    : clear all channel/section histories (idle only)
//   ovf_clr     : clear sticky overflow flag
//   ovf         : sticky flag, set when any section output saturates
module iir_biquad_cascade #(
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned COEF_FRAC    = 14,
   parameter int unsigned NUM_SECTIONS = 4,
   parameter int unsigned NUM_CH       = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   iir_biquad_cascade_if.slave      io,
   input  logic                     coef_we,
   input  logic [5:0]               coef_addr,
   input  logic signed [DATA_W-1:0] coef_data,
   input  logic                     hist_clr,
   input  logic                     ovf_clr,
   output logic                     ovf
);
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned SEC_W = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
   localparam int unsigned NCOEF = 5 * NUM_SECTIONS;
   localparam int unsigned CI_W  = $clog2(NCOEF);
   localparam int unsigned AW    = 2 * DATA_W + 4;
   localparam int unsigned PW    = 2 * DATA_W;

   localparam logic signed [DATA_W-1:0] UnityV = DATA_W'(1) << COEF_FRAC;
   localparam logic signed [AW-1:0]     RndV   = AW'(1) << (COEF_FRAC - 1);
   localparam logic signed [AW-1:0]     MaxV   = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [AW-1:0]     MinV   = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StMac, StWb, StOut} state_e;

   state_e                   state_q, state_d;
   logic [2:0]               tap_q, tap_d;
   logic [SEC_W-1:0]         sec_q, sec_d;
   logic [CH_W-1:0]          ch_q;
   logic signed [DATA_W-1:0] x0_q;   // current section input; holds final output after last WB
   logic signed [AW-1:0]     acc_q, acc_d;
   logic                     out_valid_q;
   logic signed [DATA_W-1:0] out_data_q;
   logic [CH_W-1:0]          out_ch_q;
   logic                     ovf_q;

   logic signed [DATA_W-1:0] coef_q [NCOEF];
   logic signed [DATA_W-1:0] x1_q [NUM_CH][NUM_SECTIONS];
   logic signed [DATA_W-1:0] x2_q [NUM_CH][NUM_SECTIONS];
   logic signed [DATA_W-1:0] y1_q [NUM_CH][NUM_SECTIONS];
   logic signed [DATA_W-1:0] y2_q [NUM_CH][NUM_SECTIONS];

   logic                     idle, accept, ch_ok, start;
   logic [CI_W-1:0]          coef_idx;
   logic signed [DATA_W-1:0] coef_sel, samp_sel, y_sat;
   logic signed [PW-1:0]     prod;
   logic signed [AW-1:0]     acc_base, rnd, shf;
   logic                     sat;

   assign idle          = (state_q == StIdle);
   assign io.in_ready   = idle && reset;
   assign accept        = io.in_valid && io.in_ready;
   assign ch_ok         = (32'(io.in_ch) < NUM_CH);
   // Out-of-range channels are consumed but never leave idle.
   assign start         = accept && ch_ok;
   assign io.out_valid  = out_valid_q;
   assign io.out_data   = out_data_q;
   assign io.out_ch     = out_ch_q;
   assign ovf           = ovf_q;

   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      sec_d   = sec_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StMac;
               tap_d   = '0;
               sec_d   = '0;
            end
         end
         StMac: begin
            if (tap_q == 3'd4) state_d = StWb;
            else               tap_d   = tap_q + 3'd1;
         end
         StWb: begin
            tap_d = '0;
            if (32'(sec_q) == NUM_SECTIONS - 1) begin
               state_d = StOut;
            end else begin
               state_d = StMac;
               sec_d   = sec_q + SEC_W'(1);
            end
         end
         StOut:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Shared MAC: taps 0..2 add b*x, taps 3..4 subtract a*y.
   always_comb begin
      coef_idx = CI_W'(32'(sec_q) * 5 + 32'(tap_q));
      coef_sel = coef_q[coef_idx];
      case (tap_q)
         3'd0:    samp_sel = x0_q;
         3'd1:    samp_sel = x1_q[ch_q][sec_q];
         3'd2:    samp_sel = x2_q[ch_q][sec_q];
         3'd3:    samp_sel = y1_q[ch_q][sec_q];
         default: samp_sel = y2_q[ch_q][sec_q];
      endcase
      prod     = PW'(coef_sel) * PW'(samp_sel);
      acc_base = (tap_q == 3'd0) ? '0 : acc_q;
      acc_d    = (tap_q >= 3'd3) ? (acc_base - AW'(prod)) : (acc_base + AW'(prod));
   end

   // Round half up, then saturate to the sample range.
   always_comb begin
      rnd = acc_q + RndV;
      shf = rnd >>> COEF_FRAC;
      sat = 1'b0;
      if (shf > MaxV) begin
         y_sat = {1'b0, {(DATA_W-1){1'b1}}};
         sat   = 1'b1;
      end else if (shf < MinV) begin
         y_sat = {1'b1, {(DATA_W-1){1'b0}}};
         sat   = 1'b1;
      end else begin
         y_sat = shf[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= StIdle;
         tap_q       <= '0;
         sec_q       <= '0;
         ch_q        <= '0;
         x0_q        <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         tap_q       <= tap_d;
         sec_q       <= sec_d;
         out_valid_q <= (state_q == StOut);
         if (state_q == StMac) acc_q <= acc_d;
         if (start) begin
            x0_q <= io.in_data;
            ch_q <= io.in_ch;
         end
         if (state_q == StWb) x0_q <= y_sat;
         if (state_q == StOut) begin
            out_data_q <= x0_q;
            out_ch_q   <= ch_q;
         end
         // Saturation in the same cycle as a clear keeps the flag set.
         if (state_q == StWb && sat) ovf_q <= 1'b1;
         else if (ovf_clr)           ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NCOEF; i++) coef_q[i] <= (i % 5 == 0) ? UnityV : '0;
      end else if (idle && coef_we && (32'(coef_addr) < NCOEF)) begin
         coef_q[CI_W'(coef_addr)] <= coef_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset || (idle && hist_clr)) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            for (int unsigned s = 0; s < NUM_SECTIONS; s++) begin
               x1_q[c][s] <= '0;
               x2_q[c][s] <= '0;
               y1_q[c][s] <= '0;
               y2_q[c][s] <= '0;
            end
         end
      end else if (state_q == StWb) begin
         x2_q[ch_q][sec_q] <= x1_q[ch_q][sec_q];
         x1_q[ch_q][sec_q] <= x0_q;
         y2_q[ch_q][sec_q] <= y1_q[ch_q][sec_q];
         y1_q[ch_q][sec_q] <= y_sat;
      end
   end
endmodule
